row_matrix_scheduler: RTL and testbench

ROW_MATRIX_SCHEDULER -- requirements
Module: row_matrix_scheduler

---
 rtl/row_matrix_scheduler.sv | 98 +++++++++
 tb/tb_row_matrix_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/row_matrix_scheduler.sv
// Arbitrates two row requesters onto one shared row-by-matrix multiplier and tags results back to their owner.
// Optional stall counters are enabled by defining ROW_SCHED_STALL_CNT_EN.
module row_matrix_scheduler #(
    parameter int W       = 16,
    parameter int LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_v,
    input  logic [8*W-1:0]  req0_a,
    output logic            req0_ready,
    input  logic            req1_v,
    input  logic [8*W-1:0]  req1_a,
    output logic            req1_ready,
    output logic [8*W-1:0]  mm_a,
    input  logic [16*W-1:0] mm_out,
    input  logic            mm_out_v,
    output logic            resp_v,
    output logic            resp_id,
    output logic [16*W-1:0] resp_d,
    output logic            err
`ifdef ROW_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]     stall0_cnt,
    output logic [15:0]     stall1_cnt
`endif
);

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    logic [0:0]     state;
    logic           last_grant;
    logic [LATENCY:0] tag_v;
    logic [LATENCY:0] tag_id;
    logic           accept;
    logic           grant_id;
    logic           drop;

    // Granting follows mm_out_v directly so the first valid multiplier cycle
    // already accepts a row, while the state register lags by one edge.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (mm_out_v) begin
            if (req0_v && req1_v) begin
                req0_ready = last_grant;
                req1_ready = ~last_grant;
            end else begin
                req0_ready = req0_v;
                req1_ready = req1_v;
            end
        end
    end

    assign accept   = req0_ready | req1_ready;
    assign grant_id = req1_ready;
    assign drop     = (state == ST_RUN) && !mm_out_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_WARMUP;
            last_grant <= 1'b1;
            mm_a       <= '0;
            tag_v      <= '0;
            tag_id     <= '0;
            err        <= 1'b0;
        end else begin
            state <= mm_out_v ? ST_RUN : ST_WARMUP;
            if (accept)
                last_grant <= grant_id;
            mm_a   <= accept ? (grant_id ? req1_a : req0_a) : '0;
            tag_v  <= drop ? '0 : {tag_v[LATENCY-1:0], accept};
            tag_id <= {tag_id[LATENCY-1:0], accept & grant_id};
            if (drop)
                err <= 1'b1;
        end
    end

    assign resp_v  = tag_v[LATENCY];
    assign resp_id = tag_id[LATENCY];
    assign resp_d  = mm_out;

`ifdef ROW_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall0_cnt <= '0;
            stall1_cnt <= '0;
        end else begin
            if (req0_v && !req0_ready && stall0_cnt != 16'hFFFF)
                stall0_cnt <= stall0_cnt + 16'd1;
            if (req1_v && !req1_ready && stall1_cnt != 16'hFFFF)
                stall1_cnt <= stall1_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_row_matrix_scheduler.sv
// Scoreboard bench for row_matrix_scheduler: directed grants, response timing, drop and reset behaviour.
module tb_row_matrix_scheduler;
    localparam int W       = 16;
    localparam int LATENCY = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_v, req1_v;
    logic [8*W-1:0]  req0_a, req1_a;
    logic            req0_ready, req1_ready;
    logic [8*W-1:0]  mm_a;
    logic [16*W-1:0] mm_out;
    logic            mm_out_v;
    logic            resp_v, resp_id;
    logic [16*W-1:0] resp_d;
    logic            err;
`ifdef ROW_SCHED_STALL_CNT_EN
    logic [15:0]     stall0_cnt, stall1_cnt;
`endif

    row_matrix_scheduler #(.W(W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req0_v(req0_v), .req0_a(req0_a), .req0_ready(req0_ready),
        .req1_v(req1_v), .req1_a(req1_a), .req1_ready(req1_ready),
        .mm_a(mm_a), .mm_out(mm_out), .mm_out_v(mm_out_v),
        .resp_v(resp_v), .resp_id(resp_id), .resp_d(resp_d), .err(err)
`ifdef ROW_SCHED_STALL_CNT_EN
        , .stall0_cnt(stall0_cnt), .stall1_cnt(stall1_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic id;
        int   due;
    } exp_t;

    exp_t           sb[$];
    int             cyc_cnt = 0;
    int             n_chk = 0;
    int             n_pass = 0;
    logic [8*W-1:0] exp_mma = '0;
    logic           ones0 = 1'b0;

    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    // Monitor: pops one expectation per resp_v cycle, and flags missing or stray responses.
    always @(negedge clk) begin
        if (resp_v) begin
            if (sb.size() == 0) begin
                chk("stray_resp_v", 256'(resp_v), 256'(1'b0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", 256'(resp_id), 256'(e.id));
                chk("resp_cycle", 256'(cyc_cnt), 256'(e.due));
                chk("resp_d", resp_d, mm_out);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc_cnt) begin
            exp_t e;
            e = sb.pop_front();
            chk("missing_resp", 256'(cyc_cnt), 256'(e.due));
        end
    end

    task automatic cyc(input logic mmv, input logic v0, input logic v1,
                       input logic er0, input logic er1);
        logic [8*W-1:0] nxt;
        mm_out_v = mmv;
        req0_v   = v0;
        req1_v   = v1;
        req0_a   = ones0 ? {8{16'h0001}} : {4{$urandom()}};
        req1_a   = {4{$urandom()}};
        mm_out   = {8{$urandom()}};
        @(negedge clk);
        chk("req0_ready", 256'(req0_ready), 256'(er0));
        chk("req1_ready", 256'(req1_ready), 256'(er1));
        chk("mm_a", 256'(mm_a), 256'(exp_mma));
        if (er0 || er1) sb.push_back('{er1, cyc_cnt + 1 + LATENCY});
        nxt = er0 ? req0_a : (er1 ? req1_a : '0);
        @(posedge clk);
        #1;
        exp_mma = rst ? '0 : nxt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_cycle(input logic mmv);
        rst = 1'b1;
        cyc(mmv, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req0_v = 0; req1_v = 0; req0_a = '0; req1_a = '0;
        mm_out = '0; mm_out_v = 0;
        @(posedge clk); #1;
        reset_cycle(1'b0);
        chk("rst_resp_v", 256'(resp_v), 256'(0));
        chk("rst_resp_id", 256'(resp_id), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_mm_a", 256'(mm_a), 256'(0));

        // Warmup holds off grants until the multiplier reports valid.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ones0 = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        ones0 = 1'b0;
        idle(6);

        // Single requesters, alternating owners.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(6);

        // Contention after reset starts with requester 0 and alternates.
        reset_cycle(1'b1);
        idle(1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1, (i % 2) == 0, (i % 2) == 1);
        idle(7);

        // Multiplier valid drops with two rows in flight.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        sb.delete();
        chk("err_set", 256'(err), 256'(1));
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(7);
        chk("err_sticky", 256'(err), 256'(1));

        // Reset with three rows in flight.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        reset_cycle(1'b1);
        chk("err_cleared", 256'(err), 256'(0));
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(7);

`ifdef ROW_SCHED_STALL_CNT_EN
        reset_cycle(1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, (i % 2) == 0, (i % 2) == 1);
        chk("stall0_cnt", 256'(stall0_cnt), 256'(5));
        chk("stall1_cnt", 256'(stall1_cnt), 256'(5));
        idle(7);
`endif

        chk("sb_drained", 256'(sb.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
